// File: rtl/cpupem_core_if.sv
// Program/debug port of cpupem_core. The board loader drives it as master.
// The core samples it as slave while idle or halted.
interface cpupem_core_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic [DATA_W-1:0] dbg_rdata;

  modport master (output prog_we, prog_addr, prog_data, input dbg_rdata);
  modport slave  (input prog_we, prog_addr, prog_data, output dbg_rdata);
endinterface

// File: rtl/cpupem_core.sv
// Accumulator CPU core: unified RAM, fetch/decode/execute FSM, Z/C flags, output port.
// Define CPUPEM_MUL_EN to make opcode 0xA a multiply; otherwise it executes as NOP.
module cpupem_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  cpupem_core_if.slave      prog,
  output logic              busy,
  output logic              halted,
  output logic [DATA_W-1:0] acc_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              flag_z,
  output logic              flag_c,
  output logic [DATA_W-1:0] out_port
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_t;
  typedef enum logic [3:0] {
    OP_NOP, OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR,  OP_XOR,
    OP_NOT, OP_JMP, OP_MUL, OP_JZ,  OP_JC,  OP_LDI, OP_OUT, OP_HLT
  } opcode_t;

  state_t            state;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] q;
  logic [DATA_W-1:0] ir;
  opcode_t           opcode;
  logic [ADDR_W-1:0] opnd;
  logic              idle;

  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;

  logic [DATA_W-1:0] nxt_acc;
  logic              nxt_z;
  logic              nxt_c;
  logic              z_upd;
  logic              jump;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
`ifdef CPUPEM_MUL_EN
  logic [2*DATA_W-1:0] prod;
`endif

  assign opcode = opcode_t'(ir[ADDR_W+3:ADDR_W]);
  assign opnd   = ir[ADDR_W-1:0];
  assign idle   = (state == IDLE) || (state == HALT);

  // DECODE addresses the operand straight from the RAM output, so EXEC sees it in q.
  always_comb begin
    rd_addr = prog.prog_addr;
    case (state)
      FETCH:   rd_addr = pc_out;
      DECODE:  rd_addr = q[ADDR_W-1:0];
      EXEC:    rd_addr = pc_out;
      default: rd_addr = prog.prog_addr;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = prog.prog_addr;
    wr_data = prog.prog_data;
    if (resetn) begin
      if (idle && prog.prog_we) begin
        wr_en = 1'b1;
      end else if (state == EXEC && opcode == OP_STA) begin
        wr_en   = 1'b1;
        wr_addr = opnd;
        wr_data = acc_out;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    q <= mem[rd_addr];
  end

  always_comb begin
    sum     = {1'b0, acc_out} + {1'b0, q};
    diff    = {1'b0, acc_out} - {1'b0, q};
`ifdef CPUPEM_MUL_EN
    prod    = {{DATA_W{1'b0}}, acc_out} * {{DATA_W{1'b0}}, q};
`endif
    nxt_acc = acc_out;
    nxt_c   = flag_c;
    z_upd   = 1'b0;
    jump    = 1'b0;
    case (opcode)
      OP_LDA: begin nxt_acc = q;                         z_upd = 1'b1; end
      OP_ADD: begin {nxt_c, nxt_acc} = sum;              z_upd = 1'b1; end
      OP_SUB: begin {nxt_c, nxt_acc} = diff;             z_upd = 1'b1; end
      OP_AND: begin nxt_acc = acc_out & q; nxt_c = 1'b0; z_upd = 1'b1; end
      OP_OR:  begin nxt_acc = acc_out | q; nxt_c = 1'b0; z_upd = 1'b1; end
      OP_XOR: begin nxt_acc = acc_out ^ q; nxt_c = 1'b0; z_upd = 1'b1; end
      OP_NOT: begin nxt_acc = ~acc_out;    nxt_c = 1'b0; z_upd = 1'b1; end
`ifdef CPUPEM_MUL_EN
      OP_MUL: begin nxt_acc = prod[DATA_W-1:0]; nxt_c = 1'b0; z_upd = 1'b1; end
`endif
      OP_LDI: begin nxt_acc = {{(DATA_W-ADDR_W){1'b0}}, opnd}; z_upd = 1'b1; end
      OP_JMP: jump = 1'b1;
      OP_JZ:  jump = flag_z;
      OP_JC:  jump = flag_c;
      default: ;
    endcase
    nxt_z = z_upd ? (nxt_acc == '0) : flag_z;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state          <= IDLE;
      busy           <= 1'b0;
      halted         <= 1'b0;
      acc_out        <= '0;
      pc_out         <= '0;
      flag_z         <= 1'b0;
      flag_c         <= 1'b0;
      out_port       <= '0;
      ir             <= '0;
      prog.dbg_rdata <= '0;
    end else begin
      case (state)
        IDLE, HALT: begin
          prog.dbg_rdata <= mem[rd_addr];
          // A program write in the same cycle takes priority over start.
          if (start && !prog.prog_we) begin
            pc_out <= '0;
            state  <= FETCH;
            busy   <= 1'b1;
            halted <= 1'b0;
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          ir     <= q;
          pc_out <= pc_out + ADDR_W'(1);
          state  <= EXEC;
        end
        EXEC: begin
          acc_out <= nxt_acc;
          flag_z  <= nxt_z;
          flag_c  <= nxt_c;
          if (opcode == OP_OUT) out_port <= acc_out;
          if (jump) pc_out <= opnd;
          if (opcode == OP_HLT) begin
            state  <= HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
